// File: rtl/cam_wr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cam_wr_ctrl
// Purpose  : Read-side sequencer for the camera line FIFO (ACLK domain).
//            Resets the FIFO at frame start, then drains it in fixed 8-beat
//            AXI4 INCR write bursts to a DDR frame buffer. Tracks frame
//            progress, flags FIFO overflow/underflow and write errors, and
//            pulses DONE once a whole frame has been acknowledged.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   START, BASEADDR        frame start pulse and frame buffer base address
//   BUSY, DONE             capture in progress / one-cycle frame-complete
//   ERR_OVER/UNDER/RESP    sticky error flags, cleared by an accepted START
//   FIFORST, FIFORD        FIFO reset and read enable
//   FIFOVALID, HASDATA     FIFO read data valid (1 cycle after FIFORD),
//                          at least 8 words readable
//   READDATA               FIFO word {pixA[23:0], pixB[23:0]}
//   BUF_OVER, BUF_UNDER    FIFO overflow / underflow flags
//   AW*, W*, B*            AXI4 write address / data / response channels
// ============================================================================
module cam_wr_ctrl #(
  parameter int FRAME_BEATS = 153600,
  parameter int ADDR_W      = 32,
  parameter int RST_CYCLES  = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASEADDR,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR_OVER,
  output logic              ERR_UNDER,
  output logic              ERR_RESP,
  output logic              FIFORST,
  output logic              FIFORD,
  input  logic              FIFOVALID,
  input  logic              HASDATA,
  input  logic [47:0]       READDATA,
  input  logic              BUF_OVER,
  input  logic              BUF_UNDER,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [63:0]       WDATA,
  output logic [7:0]        WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY
);

  localparam int BEAT_W = $clog2(FRAME_BEATS + 1);
  localparam int RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  // Beat count at the start of the final burst of a frame.
  localparam logic [BEAT_W-1:0] LAST_BURST_BASE = BEAT_W'(FRAME_BEATS - 8);
  localparam logic [RST_W-1:0]  RST_LAST        = RST_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FRST = 3'd1,
    S_WAIT = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [ADDR_W-1:0]   addr;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [RST_W-1:0]    rst_cnt;
  logic                busy;
  logic                done;
  logic                err_over;
  logic                err_under;
  logic                err_resp;

  // Skid buffer: buf0 is the head presented on WDATA, buf1 the second slot.
  logic [47:0]         buf0;
  logic [47:0]         buf1;
  logic [1:0]          occ;
  logic                inflight;     // a FIFO read was issued last cycle
  logic [3:0]          rd_issued;    // reads issued in the current burst
  logic [2:0]          wbeat;        // beats accepted in the current burst
  logic [1:0]          pending;
  logic                w_valid;
  logic                w_pop;

  assign pending = occ + {1'b0, inflight};
  assign w_pop   = WVALID & WREADY;

  // Constant AXI attributes: 8 beats of 8 bytes, incrementing.
  assign AWLEN   = 8'd7;
  assign AWSIZE  = 3'd3;
  assign AWBURST = 2'b01;
  assign WSTRB   = 8'hFF;

  assign AWADDR    = addr;
  assign WDATA     = {8'h00, buf0[47:24], 8'h00, buf0[23:0]};
  assign BUSY      = busy;
  assign DONE      = done;
  assign ERR_OVER  = err_over;
  assign ERR_UNDER = err_under;
  assign ERR_RESP  = err_resp;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    FIFORST   = 1'b0;
    AWVALID   = 1'b0;
    BREADY    = 1'b0;
    w_valid   = 1'b0;
    WVALID    = 1'b0;
    WLAST     = 1'b0;
    FIFORD    = 1'b0;

    // Reads may start while AW is pending (read-ahead); the occupancy rule
    // keeps buffered plus in-flight words within the two skid slots.
    if ((state == S_AW || state == S_W) && (rd_issued < 4'd8) && (pending < 2'd2)) begin
      FIFORD = 1'b1;
    end

    w_valid = (state == S_W) && (occ != 2'd0);
    WVALID  = w_valid;
    WLAST   = w_valid && (wbeat == 3'd7);

    case (state)
      S_IDLE: begin
        if (START) state_nxt = S_FRST;
      end
      S_FRST: begin
        FIFORST = 1'b1;
        if (rst_cnt == RST_LAST) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (HASDATA) state_nxt = S_AW;
      end
      S_AW: begin
        AWVALID = 1'b1;
        if (AWREADY) state_nxt = S_W;
      end
      S_W: begin
        if (w_valid && WREADY && (wbeat == 3'd7)) state_nxt = S_B;
      end
      S_B: begin
        BREADY = 1'b1;
        if (BVALID) state_nxt = (beat_cnt == LAST_BURST_BASE) ? S_IDLE : S_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame control: address, beat counter, status and error flags
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      addr      <= '0;
      beat_cnt  <= '0;
      rst_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_over  <= 1'b0;
      err_under <= 1'b0;
      err_resp  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            addr      <= {BASEADDR[ADDR_W-1:6], 6'b0};
            beat_cnt  <= '0;
            rst_cnt   <= '0;
            busy      <= 1'b1;
            err_over  <= 1'b0;
            err_under <= 1'b0;
            err_resp  <= 1'b0;
          end
        end
        S_FRST: begin
          rst_cnt <= (rst_cnt == RST_LAST) ? '0 : rst_cnt + 1'b1;
        end
        S_B: begin
          if (BVALID) begin
            if (BRESP != 2'b00) err_resp <= 1'b1;
            addr <= addr + ADDR_W'(64);
            if (beat_cnt == LAST_BURST_BASE) begin
              beat_cnt <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(8);
            end
          end
        end
        default: ;
      endcase
      // busy is low in IDLE, so these never collide with the START clear.
      if (busy && BUF_OVER)  err_over  <= 1'b1;
      if (busy && BUF_UNDER) err_under <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO read issue and skid buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      buf0      <= '0;
      buf1      <= '0;
      occ       <= '0;
      inflight  <= 1'b0;
      rd_issued <= '0;
      wbeat     <= '0;
    end else begin
      inflight <= FIFORD;
      if (FIFORD) rd_issued <= rd_issued + 4'd1;

      if (w_pop) begin
        if (WLAST) begin
          // All 8 reads are complete before the 8th beat is consumed.
          rd_issued <= '0;
          wbeat     <= '0;
        end else begin
          wbeat <= wbeat + 3'd1;
        end
      end

      if (FIFOVALID && w_pop) begin
        if (occ == 2'd1) begin
          buf0 <= READDATA;
        end else begin
          buf0 <= buf1;
          buf1 <= READDATA;
        end
      end else if (w_pop) begin
        buf0 <= buf1;
        occ  <= occ - 2'd1;
      end else if (FIFOVALID) begin
        if (occ == 2'd0) buf0 <= READDATA;
        else             buf1 <= READDATA;
        occ <= occ + 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cam_wr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cam_wr_ctrl
// Purpose  : Self-checking bench for cam_wr_ctrl with a behavioural FIFO,
//            AXI slave responder and frame-level reference expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_wr_ctrl;

  localparam int FB = 16;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        START = 1'b0;
  logic [31:0] BASEADDR = '0;
  logic        BUSY, DONE, ERR_OVER, ERR_UNDER, ERR_RESP, FIFORST, FIFORD;
  logic        FIFOVALID, HASDATA, BUF_OVER, BUF_UNDER;
  logic [47:0] READDATA;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;

  always #5 ACLK = ~ACLK;

  cam_wr_ctrl #(.FRAME_BEATS(FB), .ADDR_W(32), .RST_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(START), .BASEADDR(BASEADDR),
    .BUSY(BUSY), .DONE(DONE), .ERR_OVER(ERR_OVER), .ERR_UNDER(ERR_UNDER),
    .ERR_RESP(ERR_RESP), .FIFORST(FIFORST), .FIFORD(FIFORD),
    .FIFOVALID(FIFOVALID), .HASDATA(HASDATA), .READDATA(READDATA),
    .BUF_OVER(BUF_OVER), .BUF_UNDER(BUF_UNDER),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Environment model state
  logic [47:0] fifo_q[$];
  logic [47:0] exp_words[$];
  logic [63:0] w_log[$];
  logic        wlast_log[$];
  logic [31:0] aw_log[$];
  int fiforst_cycles, awvalid_cycles, fiford_cycles, done_count, b_count;
  int b_pending, b_idx, rd_total, w_total, max_out, stable_viol, order_viol;
  int attr_viol, neg_cnt, first_aw_neg, pushed;
  int err_idx = -1;
  bit rnd_mode = 0, word_mode = 0, hold_hasdata = 0, burst_open = 0, fifo_ge8 = 0;
  logic        s_rd, s_frst, prev_stall;
  logic [63:0] prev_wdata, tmp64;

  assign HASDATA = fifo_ge8 && !hold_hasdata;

  function automatic logic [63:0] fmt(input logic [47:0] w);
    return {8'h00, w[47:24], 8'h00, w[23:0]};
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int k);
    logic [31:0] a;
    a = base & 32'hFFFF_FFC0;
    return a + 32'(64 * k);
  endfunction

  // Monitor at negedge, FIFO + AXI slave responses driven just after posedge.
  initial begin
    FIFOVALID = 0; READDATA = '0; AWREADY = 0; WREADY = 0; BVALID = 0;
    BRESP = 2'b00; BUF_OVER = 0; BUF_UNDER = 0;
    neg_cnt = 0; pushed = 0; b_pending = 0; b_idx = 0; prev_stall = 0;
    forever begin
      @(negedge ACLK);
      neg_cnt++;
      s_rd   = FIFORD;
      s_frst = FIFORST;
      if (!ARESETN) begin
        b_pending = 0; burst_open = 0; prev_stall = 0; s_rd = 0;
      end else begin
        if (FIFORST) fiforst_cycles++;
        if (AWVALID) begin
          awvalid_cycles++;
          if (first_aw_neg < 0) first_aw_neg = neg_cnt;
          if (AWLEN !== 8'd7 || AWSIZE !== 3'd3 || AWBURST !== 2'b01) attr_viol++;
        end
        if (AWVALID && AWREADY) begin
          if (burst_open) order_viol++;
          burst_open = 1;
          aw_log.push_back(AWADDR);
        end
        if (FIFORD) begin fiford_cycles++; rd_total++; end
        if (prev_stall && (!WVALID || WDATA !== prev_wdata)) stable_viol++;
        prev_stall = WVALID && !WREADY;
        prev_wdata = WDATA;
        if (WVALID && WREADY) begin
          if (WSTRB !== 8'hFF) attr_viol++;
          w_log.push_back(WDATA);
          wlast_log.push_back(WLAST);
          w_total++;
          if (WLAST) b_pending++;
        end
        if (rd_total - w_total > max_out) max_out = rd_total - w_total;
        if (BVALID && BREADY) begin
          b_count++; b_pending--; b_idx++; burst_open = 0;
        end
        if (DONE) done_count++;
      end
      @(posedge ACLK);
      #1;
      FIFOVALID = s_rd;
      if (s_rd) READDATA = (fifo_q.size() > 0) ? fifo_q.pop_front() : 48'h0;
      if (s_frst) begin
        fifo_q.delete(); exp_words.delete(); pushed = 0; b_idx = 0;
      end else if (pushed < FB) begin
        tmp64 = {$urandom(), $urandom()};
        if (word_mode) tmp64 = 64'(pushed);
        fifo_q.push_back(tmp64[47:0]);
        exp_words.push_back(tmp64[47:0]);
        pushed++;
      end
      fifo_ge8 = (fifo_q.size() >= 8);
      AWREADY  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      WREADY   = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      BVALID   = (b_pending > 0);
      BRESP    = (BVALID && b_idx == err_idx) ? 2'b10 : 2'b00;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1);
  end

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); wlast_log.delete();
    fiforst_cycles = 0; awvalid_cycles = 0; fiford_cycles = 0; done_count = 0;
    b_count = 0; rd_total = 0; w_total = 0; max_out = 0; stable_viol = 0;
    order_viol = 0; attr_viol = 0; first_aw_neg = -1;
  endtask

  task automatic pulse_start(input logic [31:0] base);
    @(posedge ACLK); #2;
    START = 1'b1; BASEADDR = base;
    @(posedge ACLK); #2;
    START = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge ACLK);
      if (done_count > 0) begin ok = 1; break; end
    end
    #2;
  endtask

  task automatic wait_beats(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge ACLK);
      if (w_total >= n) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge ACLK);
    #2;
    tests_run++;
    if ({BUSY, DONE, ERR_OVER, ERR_UNDER, ERR_RESP, FIFORST, FIFORD, AWVALID, WVALID, WLAST, BREADY} !== 11'b0) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b want 0", {BUSY, DONE, ERR_OVER, ERR_UNDER, ERR_RESP, FIFORST, FIFORD, AWVALID, WVALID, WLAST, BREADY});
    end
    tests_run++;
    if (AWADDR !== 32'h0 || WDATA !== 64'h0) begin
      tests_failed++; $display("FAIL reset_data: awaddr=%h wdata=%h want 0", AWADDR, WDATA);
    end
    tests_run++;
    if ({AWLEN, AWSIZE, AWBURST, WSTRB} !== {8'd7, 3'd3, 2'b01, 8'hFF}) begin
      tests_failed++; $display("FAIL reset_const: got %h want %h", {AWLEN, AWSIZE, AWBURST, WSTRB}, {8'd7, 3'd3, 2'b01, 8'hFF});
    end
    @(negedge ACLK); ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #2;
    tests_run++;
    if (BUSY !== 1'b0 || FIFORST !== 1'b0) begin
      tests_failed++; $display("FAIL reset_idle: busy=%b fiforst=%b want 0 0", BUSY, FIFORST);
    end
  endtask

  task automatic test_basic();
    bit ok;
    rnd_mode = 0; word_mode = 0; err_idx = -1;
    clear_logs();
    pulse_start(32'h1000_0013);
    wait_done(3000, ok);
    repeat (2) @(posedge ACLK);
    #2;
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL basic_done_timeout: got no DONE want DONE"); end
    tests_run++;
    if (fiforst_cycles != 16) begin tests_failed++; $display("FAIL basic_fiforst_len: got %0d want 16", fiforst_cycles); end
    tests_run++;
    if (aw_log.size() != 2) begin
      tests_failed++; $display("FAIL basic_aw_count: got %0d want 2", aw_log.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if (aw_log[k] !== exp_addr(32'h1000_0013, k)) begin
          tests_failed++; $display("FAIL basic_awaddr%0d: got %h want %h", k, aw_log[k], exp_addr(32'h1000_0013, k));
        end
      end
    end
    tests_run++;
    if (w_log.size() != FB || exp_words.size() != FB) begin
      tests_failed++; $display("FAIL basic_w_count: got %0d want %0d", w_log.size(), FB);
    end else begin
      for (int i = 0; i < FB; i++) begin
        tests_run++;
        if (w_log[i] !== fmt(exp_words[i]) || wlast_log[i] !== (i % 8 == 7)) begin
          tests_failed++; $display("FAIL basic_beat%0d: got %h last=%b want %h last=%b", i, w_log[i], wlast_log[i], fmt(exp_words[i]), (i % 8 == 7));
        end
      end
    end
    tests_run++;
    if (done_count != 1 || BUSY !== 1'b0 || b_count != 2) begin
      tests_failed++; $display("FAIL basic_end: done=%0d busy=%b b=%0d want 1 0 2", done_count, BUSY, b_count);
    end
    tests_run++;
    if (order_viol != 0 || attr_viol != 0) begin
      tests_failed++; $display("FAIL basic_axi_rules: order=%0d attr=%0d want 0 0", order_viol, attr_viol);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    rnd_mode = 1; word_mode = 1; err_idx = -1;
    clear_logs();
    pulse_start(32'h2000_0000);
    wait_done(5000, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL bp_done_timeout: got no DONE want DONE"); end
    tests_run++;
    if (w_log.size() != FB) begin
      tests_failed++; $display("FAIL bp_w_count: got %0d want %0d", w_log.size(), FB);
    end else begin
      for (int i = 0; i < FB; i++) begin
        tests_run++;
        if (w_log[i] !== fmt(48'(i))) begin
          tests_failed++; $display("FAIL bp_beat%0d: got %h want %h", i, w_log[i], fmt(48'(i)));
        end
      end
    end
    tests_run++;
    if (max_out > 2) begin tests_failed++; $display("FAIL bp_outstanding: got %0d want <=2", max_out); end
    tests_run++;
    if (stable_viol != 0 || order_viol != 0) begin
      tests_failed++; $display("FAIL bp_stability: stable=%0d order=%0d want 0 0", stable_viol, order_viol);
    end
    rnd_mode = 0; word_mode = 0;
  endtask

  task automatic test_hasdata_hold();
    bit ok;
    int rise;
    hold_hasdata = 1; err_idx = -1;
    clear_logs();
    pulse_start(32'h0000_8000);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge ACLK);
      if (fiforst_cycles >= 16 && !FIFORST) begin ok = 1; break; end
    end
    repeat (100) @(posedge ACLK);
    #2;
    tests_run++;
    if (!ok || awvalid_cycles != 0 || fiford_cycles != 0) begin
      tests_failed++; $display("FAIL hold_quiet: frst_ok=%b aw=%0d rd=%0d want 1 0 0", ok, awvalid_cycles, fiford_cycles);
    end
    hold_hasdata = 0;
    rise = neg_cnt;
    wait_done(3000, ok);
    tests_run++;
    if (first_aw_neg != rise + 2) begin
      tests_failed++; $display("FAIL hold_aw_latency: got %0d want %0d", first_aw_neg - rise - 1, 1);
    end
    tests_run++;
    if (!ok || w_log.size() != FB) begin
      tests_failed++; $display("FAIL hold_frame: done=%b beats=%0d want 1 %0d", ok, w_log.size(), FB);
    end
  endtask

  task automatic test_bresp_err();
    bit ok;
    err_idx = 0;
    clear_logs();
    pulse_start(32'h3000_0000);
    wait_done(3000, ok);
    tests_run++;
    if (!ok || ERR_RESP !== 1'b1 || b_count != 2 || w_log.size() != FB) begin
      tests_failed++; $display("FAIL bresp_set: done=%b err=%b b=%0d beats=%0d want 1 1 2 %0d", ok, ERR_RESP, b_count, w_log.size(), FB);
    end
    err_idx = -1;
    clear_logs();
    pulse_start(32'h3000_1000);
    tests_run++;
    if (ERR_RESP !== 1'b0 || BUSY !== 1'b1) begin
      tests_failed++; $display("FAIL bresp_clear: err=%b busy=%b want 0 1", ERR_RESP, BUSY);
    end
    wait_done(3000, ok);
    tests_run++;
    if (!ok || ERR_RESP !== 1'b0) begin
      tests_failed++; $display("FAIL bresp_clean_frame: done=%b err=%b want 1 0", ok, ERR_RESP);
    end
  endtask

  task automatic test_over_busy_start();
    bit ok;
    err_idx = -1;
    clear_logs();
    pulse_start(32'h4000_0080);
    wait_beats(3, ok);
    #2; BUF_OVER = 1'b1;
    @(posedge ACLK); #2; BUF_OVER = 1'b0;
    pulse_start(32'h5000_0000);
    wait_done(3000, ok);
    tests_run++;
    if (!ok || ERR_OVER !== 1'b1 || ERR_UNDER !== 1'b0) begin
      tests_failed++; $display("FAIL over_sticky: done=%b over=%b under=%b want 1 1 0", ok, ERR_OVER, ERR_UNDER);
    end
    tests_run++;
    if (aw_log.size() != 2 || aw_log[0] !== exp_addr(32'h4000_0080, 0) || aw_log[1] !== exp_addr(32'h4000_0080, 1)) begin
      tests_failed++; $display("FAIL busy_start_addr: count=%0d first=%h want 2 %h", aw_log.size(), (aw_log.size() > 0) ? aw_log[0] : 32'h0, exp_addr(32'h4000_0080, 0));
    end
    repeat (5) @(posedge ACLK);
    #2;
    tests_run++;
    if (fiforst_cycles != 16 || done_count != 1 || BUSY !== 1'b0 || ERR_OVER !== 1'b1) begin
      tests_failed++; $display("FAIL busy_start_ignored: frst=%0d done=%0d busy=%b over=%b want 16 1 0 1", fiforst_cycles, done_count, BUSY, ERR_OVER);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    err_idx = -1;
    clear_logs();
    pulse_start(32'h6000_0000);
    wait_beats(4, ok);
    #3; ARESETN = 1'b0;
    #1;
    tests_run++;
    if (!ok || {BUSY, DONE, FIFORST, FIFORD, AWVALID, WVALID, WLAST, BREADY} !== 8'b0 || WDATA !== 64'h0 || AWADDR !== 32'h0) begin
      tests_failed++; $display("FAIL areset_outputs: ok=%b ctrl=%b wdata=%h awaddr=%h want 1 0 0 0", ok, {BUSY, DONE, FIFORST, FIFORD, AWVALID, WVALID, WLAST, BREADY}, WDATA, AWADDR);
    end
    repeat (3) @(posedge ACLK);
    @(negedge ACLK); #1; ARESETN = 1'b1;
    repeat (5) @(posedge ACLK);
    #2;
    tests_run++;
    if (done_count != 0 || BUSY !== 1'b0) begin
      tests_failed++; $display("FAIL areset_abandon: done=%0d busy=%b want 0 0", done_count, BUSY);
    end
    clear_logs();
    pulse_start(32'h6000_0100);
    wait_done(3000, ok);
    tests_run++;
    if (!ok || fiforst_cycles != 16 || aw_log.size() != 2 || aw_log[0] !== 32'h6000_0100) begin
      tests_failed++; $display("FAIL areset_restart: done=%b frst=%0d aw=%0d want 1 16 2", ok, fiforst_cycles, aw_log.size());
    end
    tests_run++;
    if (w_log.size() != FB || exp_words.size() != FB || w_log[0] !== fmt(exp_words[0]) || w_log[FB-1] !== fmt(exp_words[FB-1])) begin
      tests_failed++; $display("FAIL areset_restart_data: beats=%0d want %0d with matching data", w_log.size(), FB);
    end
  endtask

  task automatic test_random_frames();
    bit ok;
    logic [31:0] base;
    bit under;
    int bad;
    for (int it = 0; it < 3; it++) begin
      rnd_mode = 1; word_mode = 0;
      base = (it == 0) ? 32'hFFFF_FFC5 : $urandom();
      err_idx = int'($urandom_range(0, 2)) - 1;
      under = (it == 1);
      clear_logs();
      pulse_start(base);
      if (under) begin
        #1; BUF_UNDER = 1'b1;
        @(posedge ACLK); #2; BUF_UNDER = 1'b0;
      end
      wait_done(5000, ok);
      tests_run++;
      if (!ok || aw_log.size() != 2 || aw_log[0] !== exp_addr(base, 0) || aw_log[1] !== exp_addr(base, 1)) begin
        tests_failed++; $display("FAIL rand%0d_aw: done=%b count=%0d base=%h want 1 2 %h %h", it, ok, aw_log.size(), base, exp_addr(base, 0), exp_addr(base, 1));
      end
      bad = 0;
      if (w_log.size() != FB || exp_words.size() != FB) bad = 1;
      else for (int i = 0; i < FB; i++) if (w_log[i] !== fmt(exp_words[i]) || wlast_log[i] !== (i % 8 == 7)) bad++;
      tests_run++;
      if (bad != 0) begin
        tests_failed++; $display("FAIL rand%0d_wdata: got %0d bad beats of %0d want 0", it, bad, w_log.size());
      end
      tests_run++;
      if (ERR_RESP !== (err_idx >= 0) || ERR_UNDER !== under || ERR_OVER !== 1'b0) begin
        tests_failed++; $display("FAIL rand%0d_flags: resp=%b under=%b over=%b want %b %b 0", it, ERR_RESP, ERR_UNDER, ERR_OVER, (err_idx >= 0), under);
      end
      tests_run++;
      if (max_out > 2 || stable_viol != 0 || order_viol != 0 || attr_viol != 0) begin
        tests_failed++; $display("FAIL rand%0d_rules: out=%0d stable=%0d order=%0d attr=%0d want <=2 0 0 0", it, max_out, stable_viol, order_viol, attr_viol);
      end
    end
    rnd_mode = 0; err_idx = -1;
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_basic();
    test_backpressure();
    test_hasdata_hold();
    test_bresp_err();
    test_over_busy_start();
    test_async_reset();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cam_wr_ctrl.md
Name: cam_wr_ctrl

Overview:
- Read-side sequencer for the camera line FIFO, in the ACLK domain.
- Resets the FIFO at frame start, then drains it in fixed 8-beat AXI4 write bursts to a DDR frame buffer.
- Tracks frame progress, flags FIFO overflow/underflow and write errors, and pulses DONE when one whole frame is stored.
- Sits between the FIFO and the AXI HP write port; register-block software drives START, BASEADDR and the status bits.

Parameters:
- FRAME_BEATS, 153600, beats per frame (one FIFO word of 2 pixels = one beat; 640x480/2); must be a multiple of 8
- ADDR_W, 32, AXI address width
- RST_CYCLES, 16, ACLK cycles that FIFORST is held high at frame start

Ports:
- ACLK  in  1  system clock
- ARESETN  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse: begin a frame capture; ignored while BUSY
- BASEADDR  in  ADDR_W  frame buffer base; sampled on accepted START, bits [5:0] forced to 0
- BUSY  out  1  capture in progress
- DONE  out  1  one-cycle pulse after the last B response of a frame
- ERR_OVER  out  1  sticky: FIFO overflow seen during the frame
- ERR_UNDER  out  1  sticky: FIFO underflow seen during the frame
- ERR_RESP  out  1  sticky: BRESP != OKAY
- FIFORST  out  1  FIFO reset
- FIFORD  out  1  FIFO read enable
- FIFOVALID  in  1  read data valid; one cycle after FIFORD
- HASDATA  in  1  at least 8 words readable
- READDATA  in  48  FIFO data {pixA[23:0], pixB[23:0]}
- BUF_OVER, BUF_UNDER  in  1 each  FIFO flags
- AWADDR  out  ADDR_W; AWLEN out 8 (constant 7); AWSIZE out 3 (constant 3); AWBURST out 2 (constant INCR); AWVALID out 1; AWREADY in 1
- WDATA  out  64  {8'h00, READDATA[47:24], 8'h00, READDATA[23:0]}
- WSTRB  out  8  constant 8'hFF
- WLAST, WVALID  out  1 each; WREADY  in  1
- BRESP  in  2; BVALID in 1; BREADY out 1

Behaviour:
- Reset: all outputs 0, except the constant AXI attribute fields. State IDLE, all counters 0, skid buffer empty.
- IDLE: on START, latch BASEADDR into the address register, clear the three ERR flags, set BUSY, and go to FRST.
- FRST: hold FIFORST=1 for RST_CYCLES cycles, then go to WAIT.
- WAIT: when HASDATA=1, drive AWADDR = current address and AWVALID=1, and go to AW.
- AW: hold AWVALID and AWADDR stable until AWREADY. Then drop AWVALID and go to W.
- W, FIFO reads:
  - A 2-entry skid buffer feeds WDATA.
  - Assert FIFORD only while reads issued this burst < 8 and (buffer occupancy + reads in flight) < 2.
  - Each FIFOVALID pushes READDATA into the buffer.
  - WVALID = buffer not empty. A beat is consumed on WVALID & WREADY.
  - WLAST=1 on the 8th beat of the burst.
  - When the last beat is accepted, go to B.
- W, read-ahead: FIFORD may be asserted in the same cycle AWVALID is first raised (read-ahead) only if the same occupancy rule holds.
- B: BREADY=1. On BVALID:
  - If BRESP != 2'b00, set ERR_RESP.
  - Advance the address by 64 and the beat counter by 8.
  - If the beat counter reaches FRAME_BEATS: pulse DONE, clear BUSY, go to IDLE. Otherwise go to WAIT.
- Burst ordering: at most one outstanding burst. AW is never issued before the previous B is received.
- Address arithmetic: modulo 2^ADDR_W. A 64-byte-aligned base means no burst crosses a 4 KB boundary.
- ERR_OVER and ERR_UNDER set whenever the corresponding flag is high while BUSY. They hold until the next accepted START.
- START while BUSY is ignored, with no effect on any state.
- ERR flags do not abort the frame. The frame always completes FRAME_BEATS beats.
- WVALID and WDATA stay stable while WREADY=0 (AXI rule). FIFORD stalls when the skid buffer is full.
- Any ARESETN assertion mid-frame returns to the reset state immediately. The partially written frame is abandoned and no DONE is pulsed.

Test Plan:
- Basic frame (FRAME_BEATS=16 override), AWREADY/WREADY/BVALID always ready, START with BASEADDR=0x1000_0013:
  - FIFORST high exactly 16 cycles.
  - Two AWs at 0x1000_0000 and 0x1000_0040, AWLEN=7.
  - 16 W beats, WLAST on beats 8 and 16.
  - One DONE pulse after the 2nd BVALID; BUSY then 0.
- Backpressure: WREADY toggling 1-0-0-1 randomly, FIFO preloaded with words 0..15:
  - WDATA sequence is exactly 0..15 in order, no duplicates or drops.
  - Never more than 2 reads outstanding beyond consumed beats.
- HASDATA held 0 for 100 cycles after FRST: no AWVALID and no FIFORD. The first AWVALID appears 1 cycle after HASDATA rises.
- BRESP=2'b10 on the first burst: ERR_RESP=1, the frame still completes, DONE pulses. A subsequent START clears ERR_RESP.
- BUF_OVER pulsed mid-frame: ERR_OVER=1 sticky through DONE. A START while BUSY is ignored (AWADDR sequence is unchanged).
- ARESETN low during the 5th W beat: all outputs 0 asynchronously. After release, no DONE, BUSY=0, and a new START runs normally from FRST.
